// File: rtl/uart_mult_byte_tx.sv
// uart_mult_byte_tx: serialises a 0x55 / payload / CRC-8 / 0xAA frame on a UART line.
module uart_mult_byte_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200,
    parameter int DATA_NUM = 14,
    parameter int GAP_BITS = 0
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      tx_start,
    input  logic [8*(DATA_NUM-3)-1:0] tx_payload,
    output logic                      uart_txd,
    output logic                      tx_busy,
    output logic                      tx_done,
    output logic [7:0]                tx_byte_idx
);
    localparam int PW = 8*(DATA_NUM-3);
    localparam logic [15:0] BPS_M1 = 16'(CLK_FREQ/UART_BPS - 1);
    localparam logic [15:0] GAP_M1 = 16'(GAP_BITS - 1);
    localparam logic [7:0] LAST = 8'(DATA_NUM-1);
    localparam logic [7:0] CRC_IDX = 8'(DATA_NUM-2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP, S_LOAD, S_DONE} state_t;

    state_t r_state, w_state;
    logic [15:0] r_cnt, w_cnt, r_bit, w_bit;
    logic [7:0] r_shift, w_shift, r_idx, w_idx, r_crc, w_crc;
    logic [PW-1:0] r_payload, w_payload;
    logic r_txd, w_txd, r_busy, w_busy, r_done, w_done;
    logic w_tick;
    logic [7:0] w_next_idx, w_next_byte;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction

    assign w_tick = (r_cnt == BPS_M1);
    assign w_next_idx = r_idx + 8'd1;
    // payload byte k sits at bits 8*(k-1); the byte after r_idx is therefore at 8*r_idx
    assign w_next_byte = (w_next_idx == LAST) ? 8'hAA :
                         (w_next_idx == CRC_IDX) ? r_crc : 8'(r_payload >> {r_idx, 3'b000});

    always_comb begin
        w_state = r_state;
        w_cnt = w_tick ? 16'd0 : r_cnt + 16'd1;
        w_bit = r_bit;
        w_shift = r_shift;
        w_idx = r_idx;
        w_crc = r_crc;
        w_payload = r_payload;
        w_txd = r_txd;
        w_busy = r_busy;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt = 16'd0;
                if (tx_start) begin
                    w_state = S_START;
                    w_payload = tx_payload;
                    w_crc = 8'h00;
                    w_shift = 8'h55;
                    w_idx = 8'd0;
                    w_txd = 1'b0;
                    w_busy = 1'b1;
                end
            end
            S_START: if (w_tick) begin
                w_state = S_DATA;
                w_bit = 16'd0;
                w_txd = r_shift[0];
            end
            S_DATA: if (w_tick) begin
                if (r_bit == 16'd7) begin
                    w_state = S_STOP;
                    w_txd = 1'b1;
                end else begin
                    w_bit = r_bit + 16'd1;
                    w_shift = r_shift >> 1;
                    w_txd = r_shift[1];
                end
            end
            S_STOP: if (w_tick) begin
                w_bit = 16'd0;
                if (r_idx == LAST) begin
                    w_state = S_DONE;
                    w_busy = 1'b0;
                    w_done = 1'b1;
                end else begin
                    w_state = (GAP_BITS > 0) ? S_GAP : S_LOAD;
                end
            end
            S_GAP: if (w_tick) begin
                w_bit = r_bit + 16'd1;
                w_state = (r_bit == GAP_M1) ? S_LOAD : S_GAP;
            end
            S_LOAD: begin
                w_cnt = 16'd0;
                w_state = S_START;
                w_idx = w_next_idx;
                w_shift = w_next_byte;
                w_crc = (w_next_idx < CRC_IDX) ? crc8(r_crc, w_next_byte) : r_crc;
                w_txd = 1'b0;
            end
            S_DONE: begin
                w_cnt = 16'd0;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            r_state <= S_IDLE;
            r_cnt <= 16'd0;
            r_bit <= 16'd0;
            r_shift <= 8'h00;
            r_idx <= 8'd0;
            r_crc <= 8'h00;
            r_payload <= '0;
            r_txd <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt <= w_cnt;
            r_bit <= w_bit;
            r_shift <= w_shift;
            r_idx <= w_idx;
            r_crc <= w_crc;
            r_payload <= w_payload;
            r_txd <= w_txd;
            r_busy <= w_busy;
            r_done <= w_done;
        end
    end

    assign uart_txd = r_txd;
    assign tx_busy = r_busy;
    assign tx_done = r_done;
    assign tx_byte_idx = r_idx;
endmodule

// File: doc/uart_mult_byte_tx.md
# uart_mult_byte_tx

Multi-byte UART frame transmitter; the send direction of the board's serial command link. It accepts a start pulse plus a payload vector, then serialises one complete frame on `uart_txd`: a 0x55 header, the payload, a CRC-8 computed internally, and a 0xAA tail. Frame layout and CRC match what the multi-byte receiver checks. It sits between the command/response logic and the FPGA's UART TX pin.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `UART_BPS`, default 115200: baud rate.
- `DATA_NUM`, default 14: total frame length in bytes, including header, CRC and tail. Legal range 4..255.
- `GAP_BITS`, default 0: extra idle (mark) bit periods inserted after each stop bit, except after the last byte.
- `sys_clk`  in  1  system clock. Everything is on the rising edge.
- `sys_rst_n`  in  1  synchronous, active-high reset. The name is historical; logic 1 resets.
- `tx_start`  in  1  one-cycle request to send a frame.
- `tx_payload`  in  8*(DATA_NUM-3)  payload bytes. Bits [7:0] are frame byte 1 and bits [15:8] are byte 2. Sampled only on an accepted `tx_start`.
- `uart_txd`  out  1  serial line. Idle is 1.
- `tx_busy`  out  1  high while a frame is in progress.
- `tx_done`  out  1  one-cycle pulse at the end of the frame.
- `tx_byte_idx`  out  8  index (0..DATA_NUM-1) of the byte currently on the line.

## Operation
- Bit period: `BPS_CNT = CLK_FREQ/UART_BPS`, using integer division; the default is 434. The bit-period counter is 16 bits wide, so `BPS_CNT` must be ≤ 65535.
- Frame bytes:
  - Byte 0 is 0x55.
  - Bytes 1..DATA_NUM-3 are the payload.
  - Byte DATA_NUM-2 is the CRC.
  - Byte DATA_NUM-1 is 0xAA.
- Byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), then `GAP_BITS` idle bits of 1.
- CRC-8 definition: polynomial 0x07, init 0x00, no reflection, no final XOR. It covers payload bytes only, never the header.
  - The CRC register clears on acceptance of `tx_start`.
  - It updates bytewise, in one cycle, as each payload byte is loaded into the shift register.
  - It is final before byte DATA_NUM-2 is loaded.
- State machine: IDLE → START → DATA → STOP → (GAP) → either LOAD_NEXT → START, or DONE → IDLE.
  - IDLE: `uart_txd`=1. On `tx_start`=1, latch `tx_payload`, clear the CRC, load byte 0, and go to START.
  - START, DATA and STOP each hold for exactly `BPS_CNT` cycles per bit. DATA shifts 8 bits.
  - After STOP (and GAP when `GAP_BITS`>0):
    - If `tx_byte_idx` < DATA_NUM-1, go to LOAD_NEXT: 1 cycle, line held at 1, index incremented, next byte selected.
    - Otherwise go to DONE.
  - DONE: 1 cycle, `tx_done`=1, then IDLE.
- `tx_start` is ignored while `tx_busy`=1. The payload latch is not disturbed mid-frame.
- `tx_start` arriving in the DONE cycle is ignored. The earliest accepted restart is the first IDLE cycle.
- Reset mid-frame: on the next edge `uart_txd` returns to 1, the state goes to IDLE, and counters and CRC clear. No partial-byte completion.

## Timing
- Reset values: `uart_txd`=1, `tx_busy`=0, `tx_done`=0, `tx_byte_idx`=0. Internal CRC = 0x00.
- All outputs are registered.
- `tx_start` is sampled high at edge N:
  - `uart_txd`=0 and `tx_busy`=1 from edge N+1.
  - `tx_byte_idx`=0 at edge N+1.
- Each byte occupies 10·`BPS_CNT` cycles plus `GAP_BITS`·`BPS_CNT` when a gap applies, plus 1 LOAD_NEXT cycle between bytes. The line stays at 1 during LOAD_NEXT.
- Total busy time: `DATA_NUM`·10·`BPS_CNT` + (`DATA_NUM`-1)·(`GAP_BITS`·`BPS_CNT`+1) cycles. The default is 60 773 cycles.
- `tx_done` is high for exactly one cycle, in the cycle after the last stop bit ends. `tx_busy` falls on the same edge `tx_done` rises.
- `tx_byte_idx` changes only on LOAD_NEXT edges.

## Test plan
- **Reset/idle:** hold `sys_rst_n`=1 for 5 cycles, then release → `uart_txd`=1, `tx_busy`=0, `tx_done`=0, `tx_byte_idx`=0. No line activity for 10 000 cycles.
- **CRC vector:** `DATA_NUM`=12, payload 0x31..0x39 ("123456789") → decoded line bytes are 55 31 32 33 34 35 36 37 38 39 F4 AA. `tx_done` pulses once.
- **Default frame and timing:** `DATA_NUM`=14, payload all 0x00 → bytes 55, eleven 00, CRC 00, AA.
  - Every bit is 434 cycles and LSB first.
  - `tx_busy` is high for exactly 60 773 cycles.
  - Loopback through the multi-byte receiver gives `response_data`=0x01.
- **Start while busy:** pulse `tx_start` with a different payload at byte 5, and again in the DONE cycle → both ignored. The frame content is unchanged, and no second frame follows.
- **Back-to-back:** pulse `tx_start` in the first IDLE cycle after `tx_done` → the next start bit appears one cycle later. The second frame is correct and the CRC is freshly cleared.
- **Reset mid-frame:** assert reset during byte 3's data bits → `uart_txd`=1 and `tx_busy`=0 on the next edge. A subsequent `tx_start` sends a full, correct frame.
